// File: rtl/multicycle_main_fsm.sv
// Multi-cycle RV32I main control FSM: sequences fetch/decode/execute/
// memory/writeback, stalls on mem_ready, flags illegal opcodes.
//
// Ports:
//   i_clk, i_rst            clock, synchronous active-high reset
//   i_opcode                instr[6:0] from the instruction register
//   i_zero                  ALU zero flag (beq)
//   i_mem_ready             memory completes the access this cycle
//   o_mem_req ... o_imm_src datapath control strobes and mux selects
//   o_illegal               sticky illegal-opcode flag
//   o_instr_retired         retired instruction count (wraps)
module multicycle_main_fsm #(
  parameter int CNT_W    = 32,
  parameter int MEM_WAIT = 1,
  parameter int EN_JAL   = 1,
  parameter int EN_LUI   = 1
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [6:0]       i_opcode,
  input  logic             i_zero,
  input  logic             i_mem_ready,
  output logic             o_mem_req,
  output logic             o_pc_write,
  output logic             o_adr_src,
  output logic             o_mem_write,
  output logic             o_ir_write,
  output logic             o_reg_write,
  output logic [1:0]       o_result_src,
  output logic [1:0]       o_alu_src_a,
  output logic [1:0]       o_alu_src_b,
  output logic [1:0]       o_alu_op,
  output logic [2:0]       o_imm_src,
  output logic             o_illegal,
  output logic [CNT_W-1:0] o_instr_retired
);

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [CNT_W-1:0] L_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECR, S_EXECI, S_ALUWB, S_BEQ,
    S_JAL, S_LUI, S_TRAP
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic             r_illegal;
  logic [CNT_W-1:0] r_cnt;

  logic       w_rdy;
  logic       w_retire;
  logic       w_pc_update;
  logic       w_branch;
  logic       w_mem_req;
  logic       w_adr_src;
  logic       w_mem_write;
  logic       w_ir_write;
  logic       w_reg_write;
  logic [1:0] w_result_src;
  logic [1:0] w_alu_src_a;
  logic [1:0] w_alu_src_b;
  logic [1:0] w_alu_op;
  logic [2:0] w_imm_src;

  assign w_rdy = (MEM_WAIT != 0) ? i_mem_ready : 1'b1;

  assign w_retire = (r_state == S_MEMWB) ||
                    (r_state == S_ALUWB) ||
                    (r_state == S_BEQ)   ||
                    ((r_state == S_MEMWRITE) && w_rdy);

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_FETCH;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_illegal <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (w_next == S_TRAP) r_illegal <= 1'b1;
      if (w_retire)         r_cnt     <= r_cnt + L_ONE;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_FETCH:    if (w_rdy) w_next = S_DECODE;
      S_DECODE: begin
        case (i_opcode)
          OP_LW, OP_SW: w_next = S_MEMADR;
          OP_R:         w_next = S_EXECR;
          OP_I:         w_next = S_EXECI;
          OP_BEQ:       w_next = S_BEQ;
          OP_JAL:       w_next = (EN_JAL != 0) ? S_JAL : S_TRAP;
          OP_LUI:       w_next = (EN_LUI != 0) ? S_LUI : S_TRAP;
          default:      w_next = S_TRAP;
        endcase
      end
      S_MEMADR:
        w_next = (i_opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
      S_MEMREAD:  if (w_rdy) w_next = S_MEMWB;
      S_MEMWB:    w_next = S_FETCH;
      S_MEMWRITE: if (w_rdy) w_next = S_FETCH;
      S_EXECR:    w_next = S_ALUWB;
      S_EXECI:    w_next = S_ALUWB;
      S_ALUWB:    w_next = S_FETCH;
      S_BEQ:      w_next = S_FETCH;
      S_JAL:      w_next = S_ALUWB;
      S_LUI:      w_next = S_ALUWB;
      S_TRAP:     w_next = S_TRAP;
      default:    w_next = S_FETCH;
    endcase
  end

  always_comb begin
    w_pc_update  = 1'b0;
    w_branch     = 1'b0;
    w_mem_req    = 1'b0;
    w_adr_src    = 1'b0;
    w_mem_write  = 1'b0;
    w_ir_write   = 1'b0;
    w_reg_write  = 1'b0;
    w_result_src = 2'b00;
    w_alu_src_a  = 2'b00;
    w_alu_src_b  = 2'b00;
    w_alu_op     = 2'b00;
    unique case (r_state)
      S_FETCH: begin
        w_mem_req    = 1'b1;
        w_alu_src_b  = 2'b10;
        w_result_src = 2'b10;
        w_ir_write   = w_rdy;
        w_pc_update  = w_rdy;
      end
      S_DECODE: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b01;
      end
      S_MEMADR: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
      end
      S_MEMREAD: begin
        w_mem_req = 1'b1;
        w_adr_src = 1'b1;
      end
      S_MEMWB: begin
        w_result_src = 2'b01;
        w_reg_write  = 1'b1;
      end
      S_MEMWRITE: begin
        w_mem_req   = 1'b1;
        w_adr_src   = 1'b1;
        w_mem_write = 1'b1;
      end
      S_EXECR: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b10;
      end
      S_EXECI: begin
        w_alu_src_a = 2'b10;
        w_alu_src_b = 2'b01;
        w_alu_op    = 2'b10;
      end
      S_ALUWB: w_reg_write = 1'b1;
      S_BEQ: begin
        w_alu_src_a = 2'b10;
        w_alu_op    = 2'b01;
        w_branch    = 1'b1;
      end
      S_JAL: begin
        w_alu_src_a = 2'b01;
        w_alu_src_b = 2'b10;
        w_pc_update = 1'b1;
      end
      S_LUI: begin
        w_alu_src_a = 2'b11;
        w_alu_src_b = 2'b01;
      end
      default: ;
    endcase
  end

  always_comb begin
    case (i_opcode)
      OP_SW:   w_imm_src = 3'b001;
      OP_BEQ:  w_imm_src = 3'b010;
      OP_JAL:  w_imm_src = 3'b011;
      OP_LUI:  w_imm_src = 3'b100;
      default: w_imm_src = 3'b000;
    endcase
  end

  // Reset forces every output low combinationally, so a pending
  // store strobe is withdrawn in the same cycle reset rises.
  assign o_mem_req       = w_mem_req   & ~i_rst;
  assign o_pc_write      = (w_pc_update | (w_branch & i_zero)) & ~i_rst;
  assign o_adr_src       = w_adr_src   & ~i_rst;
  assign o_mem_write     = w_mem_write & ~i_rst;
  assign o_ir_write      = w_ir_write  & ~i_rst;
  assign o_reg_write     = w_reg_write & ~i_rst;
  assign o_result_src    = i_rst ? 2'b00 : w_result_src;
  assign o_alu_src_a     = i_rst ? 2'b00 : w_alu_src_a;
  assign o_alu_src_b     = i_rst ? 2'b00 : w_alu_src_b;
  assign o_alu_op        = i_rst ? 2'b00 : w_alu_op;
  assign o_imm_src       = i_rst ? 3'b000 : w_imm_src;
  assign o_illegal       = r_illegal & ~i_rst;
  assign o_instr_retired = i_rst ? '0 : r_cnt;

endmodule

// File: tb/tb_multicycle_main_fsm.sv
// Scoreboard bench for multicycle_main_fsm: an instruction-level
// model queues per-cycle expectations, monitors pop and compare.
module tb_multicycle_main_fsm;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst[2];
  logic [6:0] op[2];
  logic       zero[2];
  logic       mrdy[2];

  logic        o0_mreq, o0_pcw, o0_adr, o0_mw, o0_irw, o0_rw, o0_ill;
  logic [1:0]  o0_rs, o0_a, o0_b, o0_op;
  logic [2:0]  o0_imm;
  logic [3:0]  o0_cnt;
  logic        o1_mreq, o1_pcw, o1_adr, o1_mw, o1_irw, o1_rw, o1_ill;
  logic [1:0]  o1_rs, o1_a, o1_b, o1_op;
  logic [2:0]  o1_imm;
  logic [31:0] o1_cnt;

  multicycle_main_fsm #(
    .CNT_W(4), .MEM_WAIT(1), .EN_JAL(1), .EN_LUI(1)
  ) u_dut0 (
    .i_clk(clk), .i_rst(rst[0]), .i_opcode(op[0]),
    .i_zero(zero[0]), .i_mem_ready(mrdy[0]),
    .o_mem_req(o0_mreq), .o_pc_write(o0_pcw), .o_adr_src(o0_adr),
    .o_mem_write(o0_mw), .o_ir_write(o0_irw), .o_reg_write(o0_rw),
    .o_result_src(o0_rs), .o_alu_src_a(o0_a), .o_alu_src_b(o0_b),
    .o_alu_op(o0_op), .o_imm_src(o0_imm), .o_illegal(o0_ill),
    .o_instr_retired(o0_cnt)
  );

  multicycle_main_fsm #(
    .CNT_W(32), .MEM_WAIT(0), .EN_JAL(0), .EN_LUI(0)
  ) u_dut1 (
    .i_clk(clk), .i_rst(rst[1]), .i_opcode(op[1]),
    .i_zero(zero[1]), .i_mem_ready(mrdy[1]),
    .o_mem_req(o1_mreq), .o_pc_write(o1_pcw), .o_adr_src(o1_adr),
    .o_mem_write(o1_mw), .o_ir_write(o1_irw), .o_reg_write(o1_rw),
    .o_result_src(o1_rs), .o_alu_src_a(o1_a), .o_alu_src_b(o1_b),
    .o_alu_op(o1_op), .o_imm_src(o1_imm), .o_illegal(o1_ill),
    .o_instr_retired(o1_cnt)
  );

  localparam logic [6:0] LW  = 7'b0000011;
  localparam logic [6:0] SW  = 7'b0100011;
  localparam logic [6:0] RR  = 7'b0110011;
  localparam logic [6:0] II  = 7'b0010011;
  localparam logic [6:0] BEQ = 7'b1100011;
  localparam logic [6:0] JAL = 7'b1101111;
  localparam logic [6:0] LUI = 7'b0110111;
  localparam logic [6:0] BAD = 7'b1111111;

  typedef enum {
    FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE,
    EXECR, EXECI, ALUWB, BRANCH, JUMP, UPPER, TRAP, RESET
  } step_e;

  typedef struct {
    logic [17:0] v;
    int unsigned cnt;
    string       tag;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  int          mw[2]    = '{1, 0};
  int          ej[2]    = '{1, 0};
  int          el[2]    = '{1, 0};
  int unsigned cmask[2] = '{32'hF, 32'hFFFF_FFFF};
  int unsigned m_cnt[2];
  bit          m_ill[2];

  int tests = 0;
  int fails = 0;

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    if (o == SW)  return 3'b001;
    if (o == BEQ) return 3'b010;
    if (o == JAL) return 3'b011;
    if (o == LUI) return 3'b100;
    return 3'b000;
  endfunction

  function automatic bit traps(input int d, input logic [6:0] o);
    if (o == JAL) return ej[d] == 0;
    if (o == LUI) return el[d] == 0;
    return !(o == LW || o == SW || o == RR || o == II || o == BEQ);
  endfunction

  // Control vector the datapath should see for one step of an
  // instruction: {mem_req,pc_write,adr_src,mem_write,ir_write,
  // reg_write,result_src,alu_src_a,alu_src_b,alu_op,imm_src,illegal}
  function automatic logic [17:0] exp_vec(input int d, input step_e s,
      input logic rdy, input logic z, input logic [6:0] o);
    logic mr, pw, ad, mwr, ir, rw;
    logic [1:0] rs, a, b, ao;
    mr = 0; pw = 0; ad = 0; mwr = 0; ir = 0; rw = 0;
    rs = 0; a = 0; b = 0; ao = 0;
    case (s)
      FETCH:    begin mr = 1; rs = 2'b10; b = 2'b10; ir = rdy; pw = rdy; end
      DECODE:   begin a = 2'b01; b = 2'b01; end
      MEMADR:   begin a = 2'b10; b = 2'b01; end
      MEMREAD:  begin mr = 1; ad = 1; end
      MEMWB:    begin rs = 2'b01; rw = 1; end
      MEMWRITE: begin mr = 1; ad = 1; mwr = 1; end
      EXECR:    begin a = 2'b10; ao = 2'b10; end
      EXECI:    begin a = 2'b10; b = 2'b01; ao = 2'b10; end
      ALUWB:    rw = 1;
      BRANCH:   begin a = 2'b10; ao = 2'b01; pw = z; end
      JUMP:     begin a = 2'b01; b = 2'b10; pw = 1; end
      UPPER:    begin a = 2'b11; b = 2'b01; end
      default: ;
    endcase
    if (s == RESET) return 18'd0;
    return {mr, pw, ad, mwr, ir, rw, rs, a, b, ao, imm_of(o), m_ill[d]};
  endfunction

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  task automatic check(input int d, input logic [17:0] v,
                       input int unsigned c, input exp_t e);
    tests++;
    if (v !== e.v) begin
      fails++;
      $display("FAIL dut%0d %s ctrl: got %b want %b",
               d, e.tag, v, e.v);
    end
    tests++;
    if ((c & cmask[d]) !== (e.cnt & cmask[d])) begin
      fails++;
      $display("FAIL dut%0d %s retired: got %0d want %0d",
               d, e.tag, c & cmask[d], e.cnt & cmask[d]);
    end
  endtask

  always @(negedge clk) begin
    if (q0.size() > 0) begin
      exp_t e;
      e = q0.pop_front();
      check(0, {o0_mreq, o0_pcw, o0_adr, o0_mw, o0_irw, o0_rw,
                o0_rs, o0_a, o0_b, o0_op, o0_imm, o0_ill},
            {28'd0, o0_cnt}, e);
    end
    if (q1.size() > 0) begin
      exp_t e;
      e = q1.pop_front();
      check(1, {o1_mreq, o1_pcw, o1_adr, o1_mw, o1_irw, o1_rw,
                o1_rs, o1_a, o1_b, o1_op, o1_imm, o1_ill},
            o1_cnt, e);
    end
  end

  task automatic do_reset(input int d);
    exp_t e;
    rst[d]  = 1'b1;
    op[d]   = 7'($urandom);
    mrdy[d] = 1'($urandom);
    zero[d] = 1'($urandom);
    e.v = 18'd0; e.cnt = 0; e.tag = "RESET";
    push(d, e);
    @(posedge clk); #1;
    rst[d]   = 1'b0;
    m_cnt[d] = 0;
    m_ill[d] = 1'b0;
  endtask

  // One instruction from FETCH. force_lo stalls the data-memory step
  // that many cycles; abort_last >= 0 asserts reset after that many
  // cycles spent in the final step (the only way out of TRAP).
  task automatic run_instr(input int d, input logic [6:0] opc,
                           input int force_lo, input int abort_last);
    step_e plan[$];
    int    lo;
    int    in_last;
    int    guard;
    lo = force_lo; in_last = 0; guard = 0;
    plan.push_back(FETCH);
    plan.push_back(DECODE);
    if (traps(d, opc))   plan.push_back(TRAP);
    else if (opc == LW)  begin plan.push_back(MEMADR); plan.push_back(MEMREAD); plan.push_back(MEMWB); end
    else if (opc == SW)  begin plan.push_back(MEMADR); plan.push_back(MEMWRITE); end
    else if (opc == RR)  begin plan.push_back(EXECR); plan.push_back(ALUWB); end
    else if (opc == II)  begin plan.push_back(EXECI); plan.push_back(ALUWB); end
    else if (opc == BEQ) plan.push_back(BRANCH);
    else if (opc == JAL) begin plan.push_back(JUMP); plan.push_back(ALUWB); end
    else                 begin plan.push_back(UPPER); plan.push_back(ALUWB); end
    for (int i = 0; i < plan.size(); i++) begin
      bit done;
      done = 1'b0;
      while (!done) begin
        exp_t e;
        logic rdy;
        bit   last;
        last = (i == plan.size() - 1);
        if (last && abort_last >= 0 && in_last == abort_last) begin
          do_reset(d);
          return;
        end
        guard++;
        if (guard > 200) begin
          tests++; fails++;
          $display("FAIL dut%0d step budget expired", d);
          return;
        end
        op[d] = (plan[i] == DECODE || plan[i] == MEMADR) ?
                opc : 7'($urandom);
        zero[d] = 1'($urandom);
        if ((plan[i] == MEMREAD || plan[i] == MEMWRITE) && lo > 0) begin
          mrdy[d] = 1'b0;
          lo--;
        end else begin
          mrdy[d] = ($urandom_range(0, 3) != 0);
        end
        rdy = (mw[d] != 0) ? mrdy[d] : 1'b1;
        e.v   = exp_vec(d, plan[i], rdy, zero[d], op[d]);
        e.cnt = m_cnt[d];
        e.tag = plan[i].name();
        push(d, e);
        @(posedge clk); #1;
        if (last) in_last++;
        if (plan[i] == TRAP) done = 1'b0;
        else if (plan[i] == FETCH || plan[i] == MEMREAD ||
                 plan[i] == MEMWRITE) done = rdy;
        else done = 1'b1;
        if (done && plan[i] == DECODE && plan[i+1] == TRAP)
          m_ill[d] = 1'b1;
        if (done && last) m_cnt[d] = m_cnt[d] + 1;
      end
    end
  endtask

  task automatic run_random(input int d, input int n);
    logic [6:0] pool[9];
    pool = '{LW, SW, RR, II, BEQ, JAL, LUI, BAD, 7'b1110011};
    for (int k = 0; k < n; k++) begin
      logic [6:0] o;
      o = pool[$urandom_range(0, 8)];
      if (traps(d, o)) run_instr(d, o, 0, $urandom_range(1, 4));
      else             run_instr(d, o, $urandom_range(0, 2), -1);
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; op[i] = '0; zero[i] = 1'b0; mrdy[i] = 1'b0;
      m_cnt[i] = 0; m_ill[i] = 1'b0;
    end
    @(posedge clk); #1;

    do_reset(0);
    run_instr(0, RR, 0, -1);
    run_instr(0, LW, 2, -1);
    for (int k = 0; k < 4; k++) run_instr(0, BEQ, 0, -1);
    run_instr(0, BAD, 0, 10);
    run_instr(0, JAL, 0, -1);
    run_instr(0, LUI, 0, -1);
    run_instr(0, SW, 1, -1);
    do_reset(0);
    for (int k = 0; k < 17; k++) run_instr(0, RR, 0, -1);
    run_instr(0, SW, 1, 1);
    run_random(0, 40);

    do_reset(1);
    run_instr(1, JAL, 0, 3);
    run_instr(1, LUI, 0, 2);
    run_instr(1, LW, 3, -1);
    run_instr(1, SW, 2, -1);
    run_random(1, 25);

    repeat (3) @(posedge clk);
    tests++;
    if (q0.size() + q1.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d pending want 0",
               q0.size() + q1.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
